// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}, held while ready_o is high.
//
// state    | meaning
// ---------+--------------------------------------------------
// FREE     | idle, waiting for start_i
// BYZERO   | divisor was zero, result is forced to 0
// ON       | one restoring iteration per cycle, DATA_W cycles
// END      | result valid, held until start_i drops
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [2*DATA_W:0]   work, work_nxt;
   logic [DATA_W-1:0]   dvsr, dvsr_nxt;
   logic                sgn_q, sgn_nxt;
   logic                op1_neg_q, op1_neg_nxt;
   logic                op2_neg_q, op2_neg_nxt;
   logic [2*DATA_W-1:0] result_nxt;
   logic                ready_nxt;

   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   op1_abs, op2_abs;
   logic [DATA_W-1:0]   quo_fix, rem_fix;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FREE;
         cnt       <= '0;
         work      <= '0;
         dvsr      <= '0;
         sgn_q     <= 1'b0;
         op1_neg_q <= 1'b0;
         op2_neg_q <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         work      <= work_nxt;
         dvsr      <= dvsr_nxt;
         sgn_q     <= sgn_nxt;
         op1_neg_q <= op1_neg_nxt;
         op2_neg_q <= op2_neg_nxt;
         result_o  <= result_nxt;
         ready_o   <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FREE: begin
            if (start_i && !annul_i)
               state_nxt = (opdata2_i == '0) ? BYZERO : ON;
         end
         BYZERO:  state_nxt = annul_i ? FREE : END;
         ON: begin
            if (annul_i)
               state_nxt = FREE;
            else if (cnt == CNT_LAST)
               state_nxt = END;
         end
         END: begin
            if (!start_i)
               state_nxt = FREE;
         end
         default: state_nxt = FREE;
      endcase
   end

   // Datapath helpers: trial subtraction against the upper half of the work reg.
   assign trial   = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, dvsr};
   assign op1_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
   assign op2_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
   assign quo_fix = (sgn_q && (op1_neg_q ^ op2_neg_q)) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
   assign rem_fix = (sgn_q && op1_neg_q) ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];

   always_comb begin
      cnt_nxt     = cnt;
      work_nxt    = work;
      dvsr_nxt    = dvsr;
      sgn_nxt     = sgn_q;
      op1_neg_nxt = op1_neg_q;
      op2_neg_nxt = op2_neg_q;
      result_nxt  = result_o;
      ready_nxt   = ready_o;
      case (state)
         FREE: begin
            ready_nxt  = 1'b0;
            result_nxt = '0;
            if (start_i && !annul_i) begin
               sgn_nxt     = signed_div_i;
               op1_neg_nxt = opdata1_i[DATA_W-1];
               op2_neg_nxt = opdata2_i[DATA_W-1];
               if (opdata2_i != '0) begin
                  cnt_nxt  = '0;
                  work_nxt = {{DATA_W{1'b0}}, op1_abs, 1'b0};
                  dvsr_nxt = op2_abs;
               end
            end
         end
         BYZERO: begin
            result_nxt = '0;
            ready_nxt  = !annul_i;
         end
         ON: begin
            if (annul_i) begin
               cnt_nxt    = '0;
               result_nxt = '0;
               ready_nxt  = 1'b0;
            end else if (cnt == CNT_LAST) begin
               cnt_nxt    = '0;
               result_nxt = {rem_fix, quo_fix};
               ready_nxt  = 1'b1;
            end else begin
               if (trial[DATA_W])
                  work_nxt = {work[2*DATA_W-1:0], 1'b0};
               else
                  work_nxt = {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
               cnt_nxt = cnt + 1'b1;
            end
         end
         END: begin
            if (!start_i) begin
               result_nxt = '0;
               ready_nxt  = 1'b0;
            end
         end
         default: begin
            result_nxt = '0;
            ready_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized
// operations compared against plain-arithmetic division.
module tb_div_iter;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              signed_div_i;
   logic [DATA_W-1:0] opdata1_i;
   logic [DATA_W-1:0] opdata2_i;
   logic              start_i;
   logic              annul_i;
   logic [2*DATA_W-1:0] result_o;
   logic              ready_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   div_iter #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = {32'd0, a};
         y = {32'd0, b};
      end
      q = x / y;
      r = x % y;
      return {r[31:0], q[31:0]};
   endfunction

   // Full transaction: start held until ready, optional hold in END, then drop start.
   task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
      logic [63:0] exp_res;
      int          exp_lat;
      int          cyc;
      exp_res = ref_div(sgn, a, b);
      exp_lat = (b == 32'd0) ? 1 : DATA_W + 1;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = 1'b1;
      tick();
      cyc = 1;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom_range(0, 1));
      while (!ready_o && cyc < 40) begin
         tick();
         cyc++;
      end
      check({tag, "_lat"}, 64'(cyc - 1), 64'(exp_lat));
      check({tag, "_res"}, result_o, exp_res);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
         check({tag, "_hold_res"}, result_o, exp_res);
      end
      start_i = 1'b0;
      tick();
      check({tag, "_drop_rdy"}, 64'(ready_o), 64'd0);
      check({tag, "_drop_res"}, result_o, 64'd0);
      tick();
   endtask

   initial begin
      logic [31:0] a, b;
      bit          sgn;
      int          pulses;

      rst = 1'b1;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      start_i = 1'b0;
      annul_i = 1'b0;
      repeat (3) tick();
      check("rst_rdy", 64'(ready_o), 64'd0);
      check("rst_res", result_o, 64'd0);
      rst = 1'b0;
      tick();

      run_div("u100_7", 1'b0, 32'd100, 32'd7, 3);
      run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
      run_div("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
      run_div("div0", 1'b1, 32'h1234_5678, 32'd0, 4);
      run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_div("zero_5", 1'b0, 32'd0, 32'd5, 0);

      // annul is ignored once the result is in END
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
      repeat (DATA_W + 2) tick();
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      check("end_annul_rdy", 64'(ready_o), 64'd1);
      check("end_annul_res", result_o, {32'd2, 32'd8});
      start_i = 1'b0;
      repeat (2) tick();

      // annul while in BYZERO returns to FREE without a ready pulse
      opdata1_i = 32'd9; opdata2_i = 32'd0; start_i = 1'b1;
      tick();
      annul_i = 1'b1; start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      check("byz_annul_rdy", 64'(ready_o), 64'd0);
      tick();

      // annul at cnt=10
      signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (11) tick();
      annul_i = 1'b1; start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      check("annul_rdy", 64'(ready_o), 64'd0);
      check("annul_res", result_o, 64'd0);
      pulses = 0;
      repeat (40) begin
         tick();
         if (ready_o) pulses++;
      end
      check("annul_no_pulse", 64'(pulses), 64'd0);
      run_div("after_annul", 1'b0, 32'd9, 32'd3, 0);

      // reset at cnt=20
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      repeat (21) tick();
      rst = 1'b1;
      tick();
      check("midrst_rdy", 64'(ready_o), 64'd0);
      check("midrst_res", result_o, 64'd0);
      rst = 1'b0; start_i = 1'b0;
      pulses = 0;
      repeat (40) begin
         tick();
         if (ready_o) pulses++;
      end
      check("midrst_no_pulse", 64'(pulses), 64'd0);
      run_div("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, 0);

      for (int n = 0; n < 1000; n++) begin
         sgn = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = $urandom_range(0, 255);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            3:       b = $urandom | 32'h8000_0000;
            4:       b = $urandom_range(1, 65535);
            default: b = $urandom;
         endcase
         run_div("rand", sgn, a, b, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
